// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared types and encodings for the issue / FU / complete path
//
// Purpose: package imported by the issue stage, the functional units and the
// complete stage. Holds the FU select and ALU function encodings, the
// issue-to-FU and FU-to-complete packets, the multiplier's internal stage
// packet, and small helpers used by the multiply unit.
// Ports: none (package).

package sys_defs;

  localparam int XLEN        = 32;
  localparam int MULT_STAGES = 4;
  localparam int PR_IDX_W    = 6;
  localparam int AR_IDX_W    = 5;
  localparam int ROB_IDX_W   = 5;

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_MULT   = 3'd1,
    FU_LOAD   = 3'd2,
    FU_STORE  = 3'd3,
    FU_BRANCH = 3'd4
  } FU_SELECT;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_SLT    = 5'h02,
    ALU_SLTU   = 5'h03,
    ALU_AND    = 5'h04,
    ALU_OR     = 5'h05,
    ALU_XOR    = 5'h06,
    ALU_SLL    = 5'h07,
    ALU_SRL    = 5'h08,
    ALU_SRA    = 5'h09,
    ALU_MUL    = 5'h0a,
    ALU_MULH   = 5'h0b,
    ALU_MULHSU = 5'h0c,
    ALU_MULHU  = 5'h0d
  } ALU_FUNC;

  typedef struct packed {
    logic                 valid;
    FU_SELECT             fu_select;
    ALU_FUNC              mult_func;
    logic [XLEN-1:0]      rs1_value;
    logic [XLEN-1:0]      rs2_value;
    logic [PR_IDX_W-1:0]  pr_idx;
    logic [AR_IDX_W-1:0]  ar_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
  } ISSUE_FU_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      result;
    logic [PR_IDX_W-1:0]  pr_idx;
    logic [AR_IDX_W-1:0]  ar_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
  } FU_COMPLETE_PACKET;

  // One multiplier pipeline register. mcand/mplier are pre-shifted so every
  // stage consumes the low slice of mplier against an already-aligned mcand.
  typedef struct packed {
    logic                 valid;
    ALU_FUNC              mult_func;
    logic [63:0]          acc;
    logic [63:0]          mcand;
    logic [63:0]          mplier;
    logic [PR_IDX_W-1:0]  pr_idx;
    logic [AR_IDX_W-1:0]  ar_idx;
    logic [ROB_IDX_W-1:0] rob_idx;
  } MULT_STAGE_PACKET;

  function automatic logic [63:0] ext_operand(input logic [XLEN-1:0] v,
                                              input logic is_signed);
    ext_operand = is_signed ? {{32{v[XLEN-1]}}, v} : {32'b0, v};
  endfunction

  // Unknown functions fall back to the low word, same as ALU_MUL.
  function automatic logic [XLEN-1:0] mult_select(input ALU_FUNC f,
                                                  input logic [63:0] p);
    case (f)
      ALU_MULH, ALU_MULHSU, ALU_MULHU: mult_select = p[63:32];
      default:                         mult_select = p[31:0];
    endcase
  endfunction

endpackage

// File: rtl/mult_stage.sv
// rtl/mult_stage.sv - one partial-product register of the pipelined multiplier
//
// Purpose: adds mcand x (low SLICE bits of mplier) into the 64-bit accumulator,
// then realigns mcand/mplier for the next stage and registers the result.
// Ports:
//   clock      in  rising-edge clock
//   reset      in  synchronous active-low reset (clears the whole register)
//   squash     in  clears valid; wins over stall
//   stall      in  hold the register contents
//   stage_in   in  previous stage register (or prepared operands for stage 0)
//   stage_out  out this stage's register

module mult_stage
  import sys_defs::*;
#(
  parameter int SLICE = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash,
  input  logic             stall,
  input  MULT_STAGE_PACKET stage_in,
  output MULT_STAGE_PACKET stage_out
);

  MULT_STAGE_PACKET stage_next;

  // Arithmetic is modulo 2^64; two's complement sign-extended operands give
  // the correct low 64 bits for every signedness combination.
  always_comb begin
    stage_next        = stage_in;
    stage_next.acc    = stage_in.acc + stage_in.mcand * 64'(stage_in.mplier[SLICE-1:0]);
    stage_next.mcand  = stage_in.mcand << SLICE;
    stage_next.mplier = stage_in.mplier >> SLICE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stage_out <= '0;
    end else if (squash) begin
      stage_out.valid <= 1'b0;
    end else if (!stall) begin
      stage_out <= stage_next;
    end
  end

endmodule

// File: rtl/mult_fu.sv
// rtl/mult_fu.sv - pipelined integer multiply functional unit
//
// Purpose: accepts one MULT issue packet per cycle, multiplies over STAGES
// registered stages and presents a completion packet to the complete stage.
// The whole pipe stalls while complete_out is valid and not accepted.
// Optional feature macro: MULT_PERF_CNT_EN (adds perf_issued, perf_completed,
// perf_stall 32-bit counters).
// Ports:
//   clock           in  rising-edge clock
//   reset           in  synchronous active-low reset
//   squash          in  kill all in-flight ops
//   issue_in        in  ISSUE_FU_PACKET from issue / register read
//   fu_ready        out unit can accept issue_in this cycle
//   complete_ready  in  complete stage takes complete_out this cycle
//   complete_out    out FU_COMPLETE_PACKET (last stage register)
//   perf_*          out event counters (MULT_PERF_CNT_EN only)

module mult_fu
  import sys_defs::*;
#(
  parameter int STAGES = MULT_STAGES,
  parameter int PR_W   = PR_IDX_W,
  parameter int ROB_W  = ROB_IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  ISSUE_FU_PACKET    issue_in,
  output logic              fu_ready,
  input  logic              complete_ready,
  output FU_COMPLETE_PACKET complete_out
`ifdef MULT_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_completed,
  output logic [31:0]       perf_stall
`endif
);

  localparam int SLICE = 64 / STAGES;

  // Packet widths come from the shared package; the parameters only have to
  // agree with it.
  if ((64 % STAGES) != 0 || PR_W != PR_IDX_W || ROB_W != ROB_IDX_W) begin : g_bad_cfg
    $error("mult_fu: STAGES must divide 64 and tag widths must match sys_defs");
  end

  logic             stall;
  logic             accept;
  logic             rs1_signed;
  logic             rs2_signed;
  MULT_STAGE_PACKET stage0_in;
  MULT_STAGE_PACKET stage_q [STAGES];
  MULT_STAGE_PACKET last;

  assign last     = stage_q[STAGES-1];
  assign stall    = last.valid && !complete_ready;
  assign fu_ready = !stall;
  assign accept   = issue_in.valid && (issue_in.fu_select == FU_MULT) && fu_ready && !squash;

  // Operand preparation. A non-accepted cycle still builds the packet but
  // with valid=0, which is the bubble.
  always_comb begin
    rs1_signed = 1'b1;
    rs2_signed = 1'b1;
    case (issue_in.mult_func)
      ALU_MULHSU: rs2_signed = 1'b0;
      ALU_MULHU: begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
      end
      default: ;
    endcase

    stage0_in           = '0;
    stage0_in.valid     = accept;
    stage0_in.mult_func = issue_in.mult_func;
    stage0_in.acc       = '0;
    stage0_in.mcand     = ext_operand(issue_in.rs1_value, rs1_signed);
    stage0_in.mplier    = ext_operand(issue_in.rs2_value, rs2_signed);
    stage0_in.pr_idx    = issue_in.pr_idx;
    stage0_in.ar_idx    = issue_in.ar_idx;
    stage0_in.rob_idx   = issue_in.rob_idx;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    MULT_STAGE_PACKET stage_d;
    if (k == 0) begin : g_first
      assign stage_d = stage0_in;
    end else begin : g_next
      assign stage_d = stage_q[k-1];
    end

    mult_stage #(
      .SLICE(SLICE)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .squash   (squash),
      .stall    (stall),
      .stage_in (stage_d),
      .stage_out(stage_q[k])
    );
  end

  // Only a word mux sits after the last register; a reset register is all
  // zeros, so the packet reads as all zeros after reset.
  always_comb begin
    complete_out         = '0;
    complete_out.valid   = last.valid;
    complete_out.result  = mult_select(last.mult_func, last.acc);
    complete_out.pr_idx  = last.pr_idx;
    complete_out.ar_idx  = last.ar_idx;
    complete_out.rob_idx = last.rob_idx;
  end

  // The realigned operands out of the last stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{last.mcand, last.mplier};

`ifdef MULT_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_issued    <= '0;
      perf_completed <= '0;
      perf_stall     <= '0;
    end else begin
      if (accept)
        perf_issued <= perf_issued + 32'd1;
      if (last.valid && complete_ready)
        perf_completed <= perf_completed + 32'd1;
      if (stall)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_fu.sv
// tb/tb_mult_fu.sv - self-checking bench for mult_fu

module tb_mult_fu;
  import sys_defs::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              squash;
  logic              complete_ready;
  logic              fu_ready;
  ISSUE_FU_PACKET    issue_in;
  FU_COMPLETE_PACKET complete_out;
`ifdef MULT_PERF_CNT_EN
  logic [31:0] perf_issued, perf_completed, perf_stall;
  logic [31:0] snap_issued, snap_completed, snap_stall;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]          result;
    logic [PR_IDX_W-1:0]  pr;
    logic [AR_IDX_W-1:0]  ar;
    logic [ROB_IDX_W-1:0] rob;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  mult_fu dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .issue_in      (issue_in),
    .fu_ready      (fu_ready),
    .complete_ready(complete_ready),
    .complete_out  (complete_out)
`ifdef MULT_PERF_CNT_EN
    ,
    .perf_issued   (perf_issued),
    .perf_completed(perf_completed),
    .perf_stall    (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input ALU_FUNC f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f)
      ALU_MULH: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[63:32];
      end
      ALU_MULHSU: begin
        p = {{32{a[31]}}, a} * {32'b0, b};
        return p[63:32];
      end
      ALU_MULHU: begin
        p = {32'b0, a} * {32'b0, b};
        return p[63:32];
      end
      default: begin
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
      end
    endcase
  endfunction

  // Scoreboard: completions are compared at the falling edge before the edge
  // that transfers them; issues are recorded the same way.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && complete_out.valid === 1'b1 && complete_ready) begin
      if (sb.size() == 0) begin
        check("spurious_completion", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_result", complete_out.result, e.result);
        check("sb_pr_idx", complete_out.pr_idx, e.pr);
        check("sb_ar_idx", complete_out.ar_idx, e.ar);
        check("sb_rob_idx", complete_out.rob_idx, e.rob);
      end
    end
    if (reset !== 1'b1 || squash) begin
      sb.delete();
    end else if (issue_in.valid && issue_in.fu_select == FU_MULT) begin
      e.result = model(issue_in.mult_func, issue_in.rs1_value, issue_in.rs2_value);
      e.pr     = issue_in.pr_idx;
      e.ar     = issue_in.ar_idx;
      e.rob    = issue_in.rob_idx;
      sb.push_back(e);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input ALU_FUNC f, input logic [31:0] a, input logic [31:0] b,
                       input logic [PR_IDX_W-1:0] pr, input logic [AR_IDX_W-1:0] ar,
                       input logic [ROB_IDX_W-1:0] rob);
    issue_in.valid     = 1'b1;
    issue_in.fu_select = FU_MULT;
    issue_in.mult_func = f;
    issue_in.rs1_value = a;
    issue_in.rs2_value = b;
    issue_in.pr_idx    = pr;
    issue_in.ar_idx    = ar;
    issue_in.rob_idx   = rob;
  endtask

  task automatic idle();
    issue_in.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hv [3];
    logic [31:0] sq [4];
    ALU_FUNC     fl [6];
    int          w;
    hv = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    sq = '{32'd1, 32'd4, 32'd9, 32'd16};
    fl = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_FUNC'(5'h1f), ALU_ADD};

    reset          = 1'b0;
    squash         = 1'b0;
    complete_ready = 1'b1;
    issue_in       = '0;
    step();
    step();
    reset = 1'b1;
    check("reset_complete_out", complete_out, 64'd0);
    check("reset_fu_ready", fu_ready, 64'd1);
    step();
    check("idle_valid", complete_out.valid, 64'd0);

    // Basic MUL and exact latency
    drive(ALU_MUL, 32'd7, 32'd8, 6'd3, 5'd1, 5'd2);
    check("basic_fu_ready_issue", fu_ready, 64'd1);
    step();
    idle();
    for (int i = 1; i <= 3; i++) begin
      check("basic_latency_valid_low", complete_out.valid, 64'd0);
      check("basic_fu_ready", fu_ready, 64'd1);
      step();
    end
    check("basic_valid", complete_out.valid, 64'd1);
    check("basic_result", complete_out.result, 64'd56);
    check("basic_pr_idx", complete_out.pr_idx, 64'd3);
    check("basic_rob_idx", complete_out.rob_idx, 64'd2);
    check("basic_fu_ready_done", fu_ready, 64'd1);
    step();

    // High-word variants back to back
    drive(ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 5'd10, 5'd10);
    step();
    drive(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd11, 5'd11, 5'd11);
    step();
    drive(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12, 5'd12, 5'd12);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("high_valid", complete_out.valid, 64'd1);
      check("high_result", complete_out.result, {32'b0, hv[i]});
    end
    step();

    // Mixed functions, corner and random operands, back to back
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      a = (i < 4) ? 32'h8000_0000 : $urandom;
      b = (i < 2) ? 32'h7FFF_FFFF : (i < 4) ? 32'h8000_0000 : $urandom;
      drive(fl[i % 6], a, b, 6'(i + 20), 5'(i), 5'(i + 7));
      check("mix_fu_ready", fu_ready, 64'd1);
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    // Backpressure
`ifdef MULT_PERF_CNT_EN
    snap_issued    = perf_issued;
    snap_completed = perf_completed;
    snap_stall     = perf_stall;
`endif
    for (int i = 1; i <= 4; i++) begin
      drive(ALU_MUL, 32'(i), 32'(i), 6'(i), 5'(i), 5'(i));
      step();
    end
    idle();
    complete_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_fu_ready_low", fu_ready, 64'd0);
      check("bp_valid_held", complete_out.valid, 64'd1);
      check("bp_result_held", complete_out.result, 64'd1);
      step();
    end
    check("bp_result_after_stall", complete_out.result, 64'd1);
    complete_ready = 1'b1;
    #1;
    check("bp_fu_ready_release", fu_ready, 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid", complete_out.valid, 64'd1);
      check("bp_drain_result", complete_out.result, {32'b0, sq[i]});
      step();
    end
    check("bp_empty", complete_out.valid, 64'd0);
`ifdef MULT_PERF_CNT_EN
    check("perf_issued", perf_issued - snap_issued, 64'd4);
    check("perf_stall", perf_stall - snap_stall, 64'd3);
    check("perf_completed", perf_completed - snap_completed, 64'd4);
`endif

    // Squash with a simultaneous issue
    for (int i = 0; i < 3; i++) begin
      drive(ALU_MUL, 32'(i + 2), 32'd3, 6'(i), 5'(i), 5'(i));
      step();
    end
    drive(ALU_MUL, 32'd9, 32'd9, 6'd40, 5'd4, 5'd4);
    squash = 1'b1;
    step();
    squash = 1'b0;
    idle();
    check("squash_valid", complete_out.valid, 64'd0);
    check("squash_fu_ready", fu_ready, 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("squash_no_completion", complete_out.valid, 64'd0);
    end

    // Reset mid-operation
    drive(ALU_MUL, 32'd11, 32'd12, 6'd1, 5'd1, 5'd1);
    step();
    drive(ALU_MULHU, 32'd13, 32'd14, 6'd2, 5'd2, 5'd2);
    step();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("midrst_complete_out", complete_out, 64'd0);
    check("midrst_fu_ready", fu_ready, 64'd1);
    drive(ALU_MUL, 32'd5, 32'd6, 6'd7, 5'd8, 5'd9);
    step();
    idle();
    for (int i = 1; i <= 3; i++) begin
      check("midrst_latency_valid_low", complete_out.valid, 64'd0);
      step();
    end
    check("midrst_valid", complete_out.valid, 64'd1);
    check("midrst_result", complete_out.result, 64'd30);
    step();

    w = 0;
    while (sb.size() != 0 && w < 20) begin
      step();
      w++;
    end
    check("sb_drained", sb.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
